// File: rtl/mf_clken_pkg.sv
// Shared types and helpers for the multi-channel NCO clock-enable generator.
// Both helpers are elaboration-time only; nothing here infers logic.
package mf_clken_pkg;

    typedef enum logic {
        RELOCK = 1'b0,
        RUN    = 1'b1
    } clken_state_t;

    // A one-channel build still needs a 1-bit channel select port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Increment giving f_out from f_ref; the real-to-integer cast rounds to nearest.
    function automatic longint unsigned freq_to_inc(input real f_ref_hz, input real f_out_hz,
                                                    input int acc_w);
        real w_scaled;
        w_scaled = (f_out_hz / f_ref_hz) * (2.0 ** acc_w);
        return longint'(w_scaled);
    endfunction

endpackage

// File: rtl/mf_clken_acc.sv
// One NCO channel: increment, start phase and phase accumulator.
// The carry out of the accumulator is registered into ce, one cycle after the wrap.
module mf_clken_acc #(
    parameter int               ACC_W      = 32,
    parameter logic [ACC_W-1:0] INC_INIT   = '0,
    parameter logic [ACC_W-1:0] PHASE_INIT = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [ACC_W-1:0] wr_phase,
    output logic             ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_phase;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign ce    = r_ce;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_inc   <= INC_INIT;
            r_phase <= PHASE_INIT;
            r_acc   <= PHASE_INIT;
            r_ce    <= 1'b0;
        end else begin
            if (wr) begin
                r_inc   <= wr_inc;
                r_phase <= wr_phase;
            end
            // A write and its relock land together, so realign to the incoming phase.
            if (load) begin
                r_acc <= wr ? wr_phase : r_phase;
            end else if (run) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            r_ce <= run & ~load & w_sum[ACC_W];
        end
    end

endmodule

// File: rtl/mf_clken_nco.sv
// Multi-channel NCO clock-enable generator with coordinated relock on every reconfiguration.
// All channels restart from their phase registers together, preserving relative phase.
module mf_clken_nco
    import mf_clken_pkg::*;
#(
    parameter int                        NUM_CH      = 3,
    parameter int                        ACC_W       = 32,
    parameter int                        LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT    = '0,
    parameter logic [NUM_CH*ACC_W-1:0]   PHASE_INIT  = '0
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [clog2_min1(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]              cfg_inc,
    input  logic [ACC_W-1:0]              cfg_phase,
    output logic [NUM_CH-1:0]             ce_out,
    output logic                          locked
);

    localparam int CNT_W = clog2_min1(LOCK_CYCLES);

    clken_state_t      r_state;
    clken_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_lock_cnt;
    logic              w_lock_done;
    logic              w_accept;
    logic              w_load;
    logic              w_run;
    logic [NUM_CH-1:0] w_wr;

    assign w_lock_done = (r_lock_cnt == CNT_W'(LOCK_CYCLES - 1));

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= RELOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        locked      = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            RELOCK: begin
                w_load = 1'b1;
                if (w_lock_done) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                cfg_ready = 1'b1;
                locked    = 1'b1;
                w_run     = 1'b1;
                if (cfg_valid) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = RELOCK;
                end
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst || w_accept) begin
            r_lock_cnt <= '0;
        end else if (r_state == RELOCK && !w_lock_done) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    // Out-of-range channel numbers match no bit, so they only trigger the relock.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = w_accept && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mf_clken_acc #(
            .ACC_W      (ACC_W),
            .INC_INIT   (INC_INIT[g*ACC_W +: ACC_W]),
            .PHASE_INIT (PHASE_INIT[g*ACC_W +: ACC_W])
        ) u_acc (
            .refclk   (refclk),
            .rst      (rst),
            .load     (w_load),
            .run      (w_run),
            .wr       (w_wr[g]),
            .wr_inc   (cfg_inc),
            .wr_phase (cfg_phase),
            .ce       (ce_out[g])
        );
    end

endmodule
